data_sram_ctrl: RTL and testbench

//  Sequences data-memory accesses for the 5-stage pipeline over an SRAM-like handshake bus (req/addr_ok/data_ok).

---
 rtl/data_sram_ctrl_pkg.sv | 41 ++++
 rtl/data_sram_ctrl_if.sv | 25 ++
 rtl/data_sram_ctrl_wdog.sv | 36 +++
 rtl/data_sram_ctrl.sv | 121 ++++++++++++
 tb/tb_data_sram_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_ctrl_pkg.sv
// Shared types for the data-memory controller: FSM states, the latched
// request record and the pipeline stall-bus layout.
package data_sram_ctrl_pkg;

  // Pipeline stall vector layout; bit STALL_MEM gates the EX->MEM register.
  localparam int unsigned STALL_W   = 6;
  localparam int unsigned STALL_MEM = 3;
  localparam logic        STOP      = 1'b1;
  localparam logic        NO_STOP   = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ADDR,
    WAIT_DATA,
    DONE
  } mem_state_e;

  // One bus request as presented on the SRAM-like interface.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Build a bus request from the EX-stage fields; any strobe set means store.
  function automatic mem_req_t pack_req(input logic [3:0]  wen,
                                        input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata);
    mem_req_t r;
    r.wr    = |wen;
    r.size  = size;
    r.wstrb = wen;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// SRAM-like data bus (req/addr_ok/data_ok handshake). The controller is the
// master; the bus bridge or memory model is the slave.
interface data_sram_ctrl_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/data_sram_ctrl_wdog.sv
// Watchdog for one outstanding data-memory access: counts cycles spent
// waiting on the bus and raises a sticky timeout flag once the limit is hit.
// Instantiated by data_sram_ctrl only when MEM_CTRL_WATCHDOG_EN is defined.
module mem_ctrl_wdog #(
  parameter int unsigned WDOG_CYCLES = 255,
  parameter int unsigned WDOG_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic timeout
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] cnt;

  // Count waiting cycles (saturating at the limit); flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active) begin
      if (cnt != LIMIT) begin
        cnt <= cnt + WDOG_W'(1);
      end
      if ((cnt + WDOG_W'(1)) == LIMIT) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_sram_ctrl.sv
// Data-memory access sequencer for the 5-stage pipeline. Issues the EX-stage
// load/store on the SRAM-like bus, stalls the pipeline until the response
// returns, and holds the returned word in a register for the MEM stage.
// Optional feature: define MEM_CTRL_WATCHDOG_EN to enable the access watchdog
// (mem_timeout); otherwise mem_timeout is tied low.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 255,
  parameter int unsigned WDOG_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  ex_req,
  input  logic [3:0]            ex_wen,
  input  logic [1:0]            ex_size,
  input  logic [31:0]           ex_addr,
  input  logic [31:0]           ex_wdata,
  data_sram_ctrl_if.master      data_sram,
  output logic [31:0]           mem_rdata,
  output logic                  stallreq_mem,
  output logic                  mem_timeout
);

  if (WDOG_CYCLES == 0 || WDOG_CYCLES >= (64'd1 << WDOG_W)) begin : g_bad_wdog_cfg
    $error("data_sram_ctrl: WDOG_CYCLES must be in 1 .. 2**WDOG_W-1");
  end

  mem_state_e state;
  mem_req_t   req_r;
  mem_req_t   ex_fields;
  mem_req_t   bus_fields;
  logic       mem_advance;

  // Only the MEM-stage stall bit matters here.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_MEM-1:0]};

  assign mem_advance = (stall[STALL_MEM] == NO_STOP);

  // Access sequencer: issue, wait for accept, wait for response, hold for MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_r     <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_req) begin
            req_r <= ex_fields;
            state <= data_sram.addr_ok ? WAIT_DATA : WAIT_ADDR;
          end
        end
        WAIT_ADDR: begin
          if (data_sram.addr_ok) begin
            state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_sram.data_ok) begin
            mem_rdata <= data_sram.rdata;
            state     <= mem_advance ? IDLE : DONE;
          end
        end
        DONE: begin
          if (mem_advance) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus fields: live EX values on first issue, latched copy while awaiting accept.
  always_comb begin
    ex_fields  = pack_req(ex_wen, ex_size, ex_addr, ex_wdata);
    bus_fields = (state == WAIT_ADDR) ? req_r : ex_fields;

    data_sram.req   = ((state == IDLE) && ex_req) || (state == WAIT_ADDR);
    data_sram.wr    = bus_fields.wr;
    data_sram.size  = bus_fields.size;
    data_sram.wstrb = bus_fields.wstrb;
    data_sram.addr  = bus_fields.addr;
    data_sram.wdata = bus_fields.wdata;
  end

  // Hold the pipeline from issue until the response arrives.
  always_comb begin
    stallreq_mem = ((state == IDLE) && ex_req)
                || (state == WAIT_ADDR)
                || ((state == WAIT_DATA) && !data_sram.data_ok);
  end

`ifdef MEM_CTRL_WATCHDOG_EN
  logic wdog_clear;
  logic wdog_active;

  // A new access starts from IDLE, so the count restarts there.
  always_comb begin
    wdog_clear  = (state == IDLE) && ex_req;
    wdog_active = (state == WAIT_ADDR) || (state == WAIT_DATA);
  end

  mem_ctrl_wdog #(
    .WDOG_CYCLES (WDOG_CYCLES),
    .WDOG_W      (WDOG_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wdog_clear),
    .active  (wdog_active),
    .timeout (mem_timeout)
  );
`else
  assign mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: directed accesses against a
// bench-driven bus slave, with a scoreboard of expected load words.
module tb_data_sram_ctrl;
  import data_sram_ctrl_pkg::*;

`ifdef MEM_CTRL_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               ex_req;
  logic [3:0]         ex_wen;
  logic [1:0]         ex_size;
  logic [31:0]        ex_addr;
  logic [31:0]        ex_wdata;
  logic [31:0]        mem_rdata;
  logic               stallreq_mem;
  logic               mem_timeout;

  data_sram_ctrl_if bus ();

  data_sram_ctrl #(
    .WDOG_CYCLES (4),
    .WDOG_W      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex_req       (ex_req),
    .ex_wen       (ex_wen),
    .ex_size      (ex_size),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .data_sram    (bus),
    .mem_rdata    (mem_rdata),
    .stallreq_mem (stallreq_mem),
    .mem_timeout  (mem_timeout)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] sb[$];
  logic [31:0] last_rd;
  bit          pending_pop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called once per sampled cycle: retire a completed access, then check the
  // MEM-stage word against the last retired expectation.
  task automatic sb_tick();
    if (pending_pop && sb.size() > 0) begin
      last_rd = sb.pop_front();
    end
    pending_pop = 1'b0;
    check("mem_rdata", mem_rdata, last_rd);
  endtask

  task automatic access(input logic [3:0] wen, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata,
                        input int unsigned addr_lat, input int unsigned data_lat,
                        input int unsigned stop_cyc,
                        input bit keep_req, input bit early_dok);
    // Issue cycle (IDLE)
    @(negedge clk);
    ex_req = 1'b1; ex_wen = wen; ex_size = size; ex_addr = addr; ex_wdata = wdata;
    stall = '0;
    bus.addr_ok = (addr_lat == 0);
    bus.data_ok = early_dok;
    bus.rdata   = 32'hBAAD_F00D;
    sb.push_back(rdata);
    #1;
    sb_tick();
    check("idle_req", bus.req, 1);
    check("idle_stallreq", stallreq_mem, 1);
    check("idle_wr", bus.wr, |wen);
    check("idle_addr", bus.addr, addr);
    // Waiting for addr_ok: bus fields must hold the original request
    for (int unsigned i = 0; i < addr_lat; i++) begin
      @(negedge clk);
      if (!keep_req) begin
        ex_req = 1'b0; ex_addr = ~addr; ex_wen = ~wen; ex_wdata = ~wdata; ex_size = ~size;
      end
      bus.addr_ok = (i == addr_lat - 1);
      bus.data_ok = 1'b0;
      #1;
      sb_tick();
      check("wa_req", bus.req, 1);
      check("wa_stallreq", stallreq_mem, 1);
      check("wa_addr", bus.addr, addr);
      check("wa_wstrb", bus.wstrb, wen);
      check("wa_wdata", bus.wdata, wdata);
      check("wa_size", bus.size, size);
      check("wa_wr", bus.wr, |wen);
    end
    // Waiting for data_ok
    for (int unsigned i = 1; i <= data_lat; i++) begin
      @(negedge clk);
      bus.addr_ok = 1'b0;
      bus.data_ok = (i == data_lat);
      bus.rdata   = (i == data_lat) ? rdata : (32'hBAD0_0000 | i);
      stall[STALL_MEM] = (i == data_lat && stop_cyc > 0) ? STOP : NO_STOP;
      #1;
      sb_tick();
      check("wd_req", bus.req, 0);
      check("wd_stallreq", stallreq_mem, (i != data_lat));
    end
    pending_pop = 1'b1;
    // Pipeline still stopped after the response: DONE, no reissue
    for (int unsigned i = 0; i < stop_cyc; i++) begin
      @(negedge clk);
      bus.data_ok = 1'b0;
      stall[STALL_MEM] = (i + 1 < stop_cyc) ? STOP : NO_STOP;
      #1;
      sb_tick();
      check("done_req", bus.req, 0);
      check("done_stallreq", stallreq_mem, 0);
    end
  endtask

  task automatic idle_cycle(input bit stray_dok);
    @(negedge clk);
    ex_req = 1'b0;
    stall = '0;
    bus.addr_ok = 1'b0;
    bus.data_ok = stray_dok;
    bus.rdata   = 32'h5A5A_5A5A;
    #1;
    sb_tick();
    check("idle_req0", bus.req, 0);
    check("idle_stall0", stallreq_mem, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; stall = '0;
    ex_req = 1'b0; ex_wen = '0; ex_size = 2'd2; ex_addr = '0; ex_wdata = '0;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0;
    last_rd = '0; pending_pop = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", bus.req, 0);
    check("rst_stallreq", stallreq_mem, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_timeout", mem_timeout, 0);
    @(negedge clk);
    rst = 1'b0;

    // lw, addr_ok in the request cycle, data_ok next
    access(4'b0000, 2'd2, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 1'b1, 1'b0);
    idle_cycle(1'b0);

    // Response while MEM is stopped for two cycles; EX keeps its request up.
    // addr_ok and data_ok together in IDLE: only addr_ok counts.
    access(4'b0000, 2'd2, 32'h0000_3000, 32'h0, 32'h3333_3333, 0, 2, 2, 1'b1, 1'b1);
    idle_cycle(1'b0);

    // Back-to-back loads
    access(4'b0000, 2'd2, 32'h0000_0100, 32'h0, 32'h1111_1111, 0, 2, 0, 1'b1, 1'b0);
    access(4'b0000, 2'd2, 32'h0000_0104, 32'h0, 32'h2222_2222, 0, 2, 0, 1'b1, 1'b0);
    idle_cycle(1'b0);

    // Half store, addr_ok after 3 wait cycles, EX drops its request meanwhile
    access(4'b0011, 2'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0000_A5A5, 3, 1, 0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Reset while waiting for data, then a stray data_ok
    @(negedge clk);
    ex_req = 1'b1; ex_wen = '0; ex_size = 2'd2; ex_addr = 32'h0000_0200; ex_wdata = '0;
    bus.addr_ok = 1'b1; bus.data_ok = 1'b0;
    @(negedge clk);
    bus.addr_ok = 1'b0;
    rst = 1'b1;
    #1;
    check("wd_pre_rst_stallreq", stallreq_mem, 1);
    @(negedge clk);
    rst = 1'b0; ex_req = 1'b0;
    bus.data_ok = 1'b1; bus.rdata = 32'h1234_5678;
    last_rd = '0;
    #1;
    check("post_rst_req", bus.req, 0);
    check("post_rst_stallreq", stallreq_mem, 0);
    check("post_rst_timeout", mem_timeout, 0);
    sb_tick();
    idle_cycle(1'b0);

    // Watchdog (limit 4): short waits never trip it, a long one does
    access(4'b0000, 2'd2, 32'h0000_0400, 32'h0, 32'h0000_0044, 1, 2, 0, 1'b1, 1'b0);
    idle_cycle(1'b0);
    check("wdog_short1", mem_timeout, 0);
    access(4'b0000, 2'd2, 32'h0000_0404, 32'h0, 32'h0000_0045, 1, 2, 0, 1'b1, 1'b0);
    idle_cycle(1'b0);
    check("wdog_short2", mem_timeout, 0);
    access(4'b0000, 2'd2, 32'h0000_0408, 32'h0, 32'h0000_0046, 6, 1, 0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    check("wdog_long", mem_timeout, WDOG_ON);
    idle_cycle(1'b0);
    check("wdog_sticky", mem_timeout, WDOG_ON);

    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
